// File: rtl/wspr_symbol_sequencer_pkg.sv
// Shared constants, symbol type and sequencer state encoding for the WSPR
// symbol sequencer. The ARMED state exists only when WSPR_SEQ_SYNC_START_EN
// is defined.
package tinywspr_pkg;

  localparam int unsigned NUM_SYMBOLS   = 162;
  localparam int unsigned SYMS_PER_BYTE = 4;
  localparam int unsigned NUM_CFG_BYTES =
    (NUM_SYMBOLS + SYMS_PER_BYTE - 1) / SYMS_PER_BYTE;

  typedef logic [1:0] symbol_t;

`ifdef WSPR_SEQ_SYNC_START_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TX,
    ST_ARMED
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TX
  } state_t;
`endif

  // Extract symbol 'slot' (0..3) from a config byte; symbol i sits in [2i+1:2i].
  function automatic symbol_t sym_of_byte(input logic [7:0] b, input logic [1:0] slot);
    return b[{slot, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/wspr_baud_timer.sv
// Symbol-period down-counter: load forces the reload value in, enable counts
// down, and tick is asserted while enabled at count 0, when it auto-reloads.
module wspr_baud_timer #(
  parameter int unsigned BAUD_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] reload_i,
  input  logic              load_i,
  input  logic              en_i,
  output logic              tick_o
);

  logic [BAUD_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == '0);

  // Counter: explicit load, otherwise decrement and wrap to the reload value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= reload_i;
    end else if (en_i) begin
      if (cnt_q == '0) cnt_q <= reload_i;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/wspr_symbol_sequencer.sv
// WSPR symbol sequencer: stores one 162-symbol frame loaded byte-wise and
// plays it out as 4-FSK tone indices at a programmable symbol period.
// Optional WSPR_SEQ_SYNC_START_EN adds sync_pulse and an ARMED state that
// defers the start of transmission to the next sync pulse.
module wspr_symbol_sequencer #(
  parameter int unsigned NUM_SYMBOLS = 162,
  parameter int unsigned BAUD_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cfg_byte,
  input  logic              cfg_valid,
  input  logic              cfg_start,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic              tx_start,
  input  logic              tx_abort,
`ifdef WSPR_SEQ_SYNC_START_EN
  input  logic              sync_pulse,
`endif
  output logic [1:0]        sym_out,
  output logic              sym_strobe,
  output logic              tx_active,
  output logic              tx_done,
  output logic              loaded,
  output logic              overflow
);

  import tinywspr_pkg::*;

  localparam int unsigned CFG_BYTES = (NUM_SYMBOLS + SYMS_PER_BYTE - 1) / SYMS_PER_BYTE;
  localparam int unsigned PTR_W     = $clog2(CFG_BYTES + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_SYMBOLS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CFG_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYMBOLS - 1);

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BAUD_W-1:0] baud_q;
  logic [7:0]        mem_q [CFG_BYTES];
  symbol_t           sym_q;
  logic              strobe_q, active_q, done_q, loaded_q, ovf_q;

  logic              wr_en, go, tick;
  logic [BAUD_W-1:0] tmr_reload;
  logic [IDX_W-1:0]  idx_nxt;
  symbol_t           nxt_sym, first_sym;

  // Start decode, timer reload source and next-symbol lookup.
  always_comb begin
    wr_en     = (state_q == ST_LOAD) && cfg_valid && !cfg_start;
    idx_nxt   = idx_q + 1'b1;
    nxt_sym   = sym_of_byte(mem_q[idx_nxt[IDX_W-1:2]], idx_nxt[1:0]);
    first_sym = sym_of_byte(mem_q[0], 2'd0);
`ifdef WSPR_SEQ_SYNC_START_EN
    go         = (state_q == ST_ARMED) && sync_pulse && !tx_abort;
    tmr_reload = baud_q;
`else
    go         = (state_q == ST_IDLE) && tx_start && loaded_q && !cfg_start;
    // baud_div feeds the counter directly on the start cycle; thereafter the latched copy
    tmr_reload = go ? baud_div : baud_q;
`endif
  end

  wspr_baud_timer #(.BAUD_W(BAUD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .reload_i (tmr_reload),
    .load_i   (go),
    .en_i     (state_q == ST_TX),
    .tick_o   (tick)
  );

  // Symbol store: written only during a load; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= cfg_byte;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      baud_q   <= '0;
      sym_q    <= '0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            state_q  <= ST_LOAD;
            ptr_q    <= '0;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
          end else begin
            if (cfg_valid && loaded_q) ovf_q <= 1'b1;
`ifdef WSPR_SEQ_SYNC_START_EN
            if (tx_start && loaded_q) begin
              state_q <= ST_ARMED;
              baud_q  <= baud_div;
            end
`endif
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            ptr_q <= '0;
          end else if (cfg_valid) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
              loaded_q <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end
        end
        ST_TX: begin
          if (tx_abort) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            sym_q    <= '0;
          end else if (tick) begin
            if (idx_q == LAST_IDX) begin
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
              sym_q    <= '0;
              done_q   <= 1'b1;
            end else begin
              idx_q    <= idx_nxt;
              sym_q    <= nxt_sym;
              strobe_q <= 1'b1;
            end
          end
        end
`ifdef WSPR_SEQ_SYNC_START_EN
        ST_ARMED: begin
          if (tx_abort) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
      // Start of transmission is shared by the direct and sync-armed paths.
      if (go) begin
        state_q  <= ST_TX;
        active_q <= 1'b1;
        strobe_q <= 1'b1;
        sym_q    <= first_sym;
        idx_q    <= '0;
`ifndef WSPR_SEQ_SYNC_START_EN
        baud_q   <= baud_div;
`endif
      end
    end
  end

  assign sym_out    = sym_q;
  assign sym_strobe = strobe_q;
  assign tx_active  = active_q;
  assign tx_done    = done_q;
  assign loaded     = loaded_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_wspr_symbol_sequencer.sv
// Self-checking bench for wspr_symbol_sequencer. Expected symbols come from a
// byte-array image of the loaded frame; per-cycle TX outputs are derived from
// the cycle offset since start with plain arithmetic.
module tb_wspr_symbol_sequencer;

  localparam int unsigned BAUD_W = 24;
  localparam int unsigned NSYM   = 162;
  localparam int unsigned NBYTES = 41;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        cfg_byte;
  logic              cfg_valid, cfg_start, tx_start, tx_abort;
  logic [BAUD_W-1:0] baud_div;
  logic [1:0]        sym_out;
  logic              sym_strobe, tx_active, tx_done, loaded, overflow;
`ifdef WSPR_SEQ_SYNC_START_EN
  logic              sync_pulse;
`endif

  always #5 clk = ~clk;

  wspr_symbol_sequencer #(.NUM_SYMBOLS(NSYM), .BAUD_W(BAUD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_byte   (cfg_byte),
    .cfg_valid  (cfg_valid),
    .cfg_start  (cfg_start),
    .baud_div   (baud_div),
    .tx_start   (tx_start),
    .tx_abort   (tx_abort),
`ifdef WSPR_SEQ_SYNC_START_EN
    .sync_pulse (sync_pulse),
`endif
    .sym_out    (sym_out),
    .sym_strobe (sym_strobe),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .loaded     (loaded),
    .overflow   (overflow)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state: frame image, loaded and overflow flags.
  logic [7:0] mbytes [NBYTES];
  logic       mloaded = 1'b0;
  logic       movf    = 1'b0;

  function automatic logic [1:0] exp_sym(input int k);
    logic [7:0] b;
    b = mbytes[k / 4];
    return b[2 * (k % 4) +: 2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tx_obs();
    return {27'd0, tx_active, tx_done, sym_strobe, sym_out};
  endfunction

  function automatic logic [31:0] flag_obs();
    return {30'd0, loaded, overflow};
  endfunction

  // Begin a load (optionally colliding a cfg_valid with cfg_start) then write n bytes.
  task automatic load_frame(input int n, input bit rnd, input logic [7:0] fixed, input bit collide);
    cfg_start = 1'b1;
    cfg_valid = collide;
    cfg_byte  = 8'($urandom);
    tick();
    cfg_start = 1'b0;
    mloaded   = 1'b0;
    movf      = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("load_flags_during", flag_obs(), 32'd0);
      cfg_byte  = rnd ? 8'($urandom) : fixed;
      cfg_valid = 1'b1;
      mbytes[i] = cfg_byte;
      tick();
    end
    cfg_valid = 1'b0;
    if (n == NBYTES) mloaded = 1'b1;
    check("load_flags_after", flag_obs(), {30'd0, mloaded, movf});
  endtask

  // Issue tx_start; with the sync option, fire sync_pulse 100 cycles later.
  task automatic start_tx(input int d);
    baud_div = BAUD_W'(d);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    baud_div = BAUD_W'($urandom);
`ifdef WSPR_SEQ_SYNC_START_EN
    for (int i = 0; i < 99; i++) tick();
    check("armed_idle", tx_obs(), 32'd0);
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
`endif
  endtask

  // Play the frame with symbol period d+1; abort at the first cycle of symbol abort_k if >= 0.
  task automatic run_tx(input int d, input int abort_k);
    int total, k, strobes;
    logic [31:0] exp;
    total   = NSYM * (d + 1);
    strobes = 0;
    start_tx(d);
    for (int t = 1; t <= total + 1; t++) begin
      if (t <= total) begin
        k   = (t - 1) / (d + 1);
        exp = {27'd0, 1'b1, 1'b0, ((t - 1) % (d + 1)) == 0, exp_sym(k)};
      end else begin
        exp = {27'd0, 1'b0, 1'b1, 1'b0, 2'b00};
      end
      check("tx_cycle", tx_obs(), exp);
      if (sym_strobe) strobes++;
      if (t <= total) begin
        cfg_valid = 1'($urandom);
        cfg_start = 1'($urandom);
        tx_start  = 1'($urandom);
        cfg_byte  = 8'($urandom);
        baud_div  = BAUD_W'($urandom);
      end else begin
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        tx_start  = 1'b0;
      end
      if (abort_k >= 0 && t == abort_k * (d + 1) + 1) begin
        tx_abort = 1'b1;
        tick();
        tx_abort  = 1'b0;
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        tx_start  = 1'b0;
        check("abort_next", tx_obs(), 32'd0);
        for (int i = 0; i < 3; i++) begin
          tick();
          check("abort_quiet", tx_obs(), 32'd0);
        end
        break;
      end
      tick();
    end
    if (abort_k < 0) begin
      check("strobe_count", 32'(strobes), 32'(NSYM));
      check("done_one_cycle", tx_obs(), 32'd0);
    end
    check("flags_after_tx", flag_obs(), {30'd0, mloaded, movf});
  endtask

  initial begin
    rst_n = 1'b0; cfg_byte = '0; cfg_valid = 1'b0; cfg_start = 1'b0;
    baud_div = '0; tx_start = 1'b0; tx_abort = 1'b0;
`ifdef WSPR_SEQ_SYNC_START_EN
    sync_pulse = 1'b0;
`endif
    tick(); tick();
    check("reset_tx", tx_obs(), 32'd0);
    check("reset_flags", flag_obs(), 32'd0);
    rst_n = 1'b1;
    tick();

    // tx_start with nothing loaded is ignored
    tx_start = 1'b1; baud_div = 24'd2;
    tick();
    tx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("nostart_unloaded", tx_obs(), 32'd0);
      tick();
    end

    // partial load of 40 bytes never reaches loaded
    load_frame(40, 1'b1, 8'h00, 1'b0);
    tick();
    check("partial_load", flag_obs(), 32'd0);

    // 0xE4 frame at baud_div=3: 0,1,2,3 repeating, 4 cycles each
    load_frame(NBYTES, 1'b0, 8'hE4, 1'b0);
    run_tx(3, -1);

    // 42nd byte sets overflow and does not alter the store
    cfg_byte = 8'h00; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    movf = 1'b1;
    check("overflow_set", flag_obs(), 32'd3);
    run_tx(0, -1);

    // tx_abort outside TX is a no-op
    tx_abort = 1'b1;
    tick();
    tx_abort = 1'b0;
    check("abort_idle_tx", tx_obs(), 32'd0);
    check("abort_idle_flags", flag_obs(), 32'd3);

    // cfg_start clears overflow and loaded
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    mloaded = 1'b0; movf = 1'b0;
    check("cfg_start_clears", flag_obs(), 32'd0);

    // random frame, abort at symbol 50, then restart from symbol 0
    load_frame(NBYTES, 1'b1, 8'h00, 1'b0);
    run_tx(int'($urandom_range(1, 4)), 50);
    run_tx(int'($urandom_range(1, 3)), -1);

    // partial load, then colliding cfg_valid+cfg_start restarts at pointer 0
    load_frame(5, 1'b1, 8'h00, 1'b0);
    load_frame(NBYTES, 1'b0, 8'h1B, 1'b1);
    run_tx(0, -1);

    // asynchronous reset in the middle of a transmission
    start_tx(2);
    for (int i = 0; i < 20; i++) tick();
    check("pre_reset_active", {31'd0, tx_active}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    mloaded = 1'b0; movf = 1'b0;
    check("async_reset_tx", tx_obs(), 32'd0);
    check("async_reset_flags", flag_obs(), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // a couple of fully random frames and periods
    for (int r = 0; r < 2; r++) begin
      load_frame(NBYTES, 1'b1, 8'h00, 1'b0);
      run_tx(int'($urandom_range(0, 2)), -1);
    end

`ifdef WSPR_SEQ_SYNC_START_EN
    // tx_abort while armed returns to idle; a later start still works
    tx_start = 1'b1; baud_div = 24'd1;
    tick();
    tx_start = 1'b0;
    tick();
    tx_abort = 1'b1;
    tick();
    tx_abort = 1'b0;
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    check("armed_abort", tx_obs(), 32'd0);
    run_tx(1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
